// File: rtl/ex_stage.sv
// Execute stage: RS/RT forwarding, ALU, multi-cycle mult/div unit with HI/LO,
// and the EX/MEM pipeline register feeding the memory stage.
module ex_stage #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] PC8_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic [31:0] EXT_E,
  input  logic [1:0]  Forward_RS_E,
  input  logic [1:0]  Forward_RT_E,
  input  logic [31:0] ALUOUT_M_fwd,
  input  logic [31:0] PC8_M_fwd,
  input  logic [31:0] mux_Wdata_out,
  output logic [31:0] IR_M,
  output logic [31:0] PC8_M,
  output logic [31:0] ALUOUT_M,
  output logic [31:0] RT_M,
  output logic        MD_BUSY
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} md_state_t;

  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [31:0] rs_fwd, rt_fwd, alu;
  logic [31:0] hi, lo, res_hi, res_lo;
  logic [CW-1:0] cnt;
  logic        skip_commit, busy_reg;
  md_state_t   state;

  logic        is_rtype, is_md_start, is_div, is_signed_div, start;
  logic        is_mthi, is_mtlo;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [63:0] md_result;

  assign opcode        = IR_E[31:26];
  assign funct         = IR_E[5:0];
  assign shamt         = IR_E[10:6];
  assign is_rtype      = (opcode == 6'h00);
  assign is_md_start   = is_rtype && (funct[5:2] == 4'b0110);
  assign is_div        = funct[1];
  assign is_signed_div = is_div && !funct[0];
  assign is_mthi       = is_rtype && (funct == 6'h11);
  assign is_mtlo       = is_rtype && (funct == 6'h13);
  assign busy_reg      = (state == BUSY);
  assign start         = is_md_start && !busy_reg;
  assign MD_BUSY       = is_md_start || busy_reg;

  // Forwarding muxes for RS and RT
  always_comb begin
    case (Forward_RS_E)
      2'd0:    rs_fwd = RS_E;
      2'd1:    rs_fwd = ALUOUT_M_fwd;
      2'd2:    rs_fwd = PC8_M_fwd;
      default: rs_fwd = mux_Wdata_out;
    endcase
    case (Forward_RT_E)
      2'd0:    rt_fwd = RT_E;
      2'd1:    rt_fwd = ALUOUT_M_fwd;
      2'd2:    rt_fwd = PC8_M_fwd;
      default: rt_fwd = mux_Wdata_out;
    endcase
  end

  // ALU result selection by opcode/funct
  always_comb begin
    alu = '0;
    if (is_rtype) begin
      case (funct)
        6'h00: alu = rt_fwd << shamt;
        6'h02: alu = rt_fwd >> shamt;
        6'h03: alu = 32'($signed(rt_fwd) >>> shamt);
        6'h04: alu = rt_fwd << rs_fwd[4:0];
        6'h06: alu = rt_fwd >> rs_fwd[4:0];
        6'h07: alu = 32'($signed(rt_fwd) >>> rs_fwd[4:0]);
        6'h10: alu = hi;
        6'h12: alu = lo;
        6'h21: alu = rs_fwd + rt_fwd;
        6'h23: alu = rs_fwd - rt_fwd;
        6'h24: alu = rs_fwd & rt_fwd;
        6'h25: alu = rs_fwd | rt_fwd;
        6'h26: alu = rs_fwd ^ rt_fwd;
        6'h27: alu = ~(rs_fwd | rt_fwd);
        6'h2A: alu = {31'd0, $signed(rs_fwd) < $signed(rt_fwd)};
        6'h2B: alu = {31'd0, rs_fwd < rt_fwd};
        default: alu = '0;
      endcase
    end else begin
      case (opcode)
        6'h09, 6'h23, 6'h2B: alu = rs_fwd + EXT_E;
        6'h0A: alu = {31'd0, $signed(rs_fwd) < $signed(EXT_E)};
        6'h0B: alu = {31'd0, rs_fwd < EXT_E};
        6'h0C: alu = rs_fwd & {16'd0, EXT_E[15:0]};
        6'h0D: alu = rs_fwd | {16'd0, EXT_E[15:0]};
        6'h0E: alu = rs_fwd ^ {16'd0, EXT_E[15:0]};
        6'h0F: alu = EXT_E << 16;
        default: alu = '0;
      endcase
    end
  end

  // Mult/div result; signed divide goes through magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 rather than overflowing.
  always_comb begin
    a_mag  = (is_signed_div && rs_fwd[31]) ? -rs_fwd : rs_fwd;
    b_mag  = (is_signed_div && rt_fwd[31]) ? -rt_fwd : rt_fwd;
    b_safe = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (is_signed_div && (rs_fwd[31] ^ rt_fwd[31])) ? -q_mag : q_mag;
    rem    = (is_signed_div && rs_fwd[31]) ? -r_mag : r_mag;
    case (funct[1:0])
      2'b00:   md_result = $signed({{32{rs_fwd[31]}}, rs_fwd}) * $signed({{32{rt_fwd[31]}}, rt_fwd});
      2'b01:   md_result = {32'd0, rs_fwd} * {32'd0, rt_fwd};
      default: md_result = {rem, quot};
    endcase
  end

  // Mult/div unit: latch result on start, count down, commit HI/LO on 1->0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      res_hi      <= '0;
      res_lo      <= '0;
      skip_commit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            res_hi      <= md_result[63:32];
            res_lo      <= md_result[31:0];
            skip_commit <= is_div && (rt_fwd == '0);
            cnt         <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state       <= BUSY;
          end else begin
            if (is_mthi) hi <= rs_fwd;
            if (is_mtlo) lo <= rs_fwd;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            if (!skip_commit) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register, loads every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IR_M     <= '0;
      PC8_M    <= '0;
      ALUOUT_M <= '0;
      RT_M     <= '0;
    end else begin
      IR_M     <= IR_E;
      PC8_M    <= PC8_E;
      ALUOUT_M <= alu;
      RT_M     <= rt_fwd;
    end
  end

endmodule
